// File: rtl/uart_tx_fifo.sv
// UART transmit FIFO: a Wishbone-style slave queues bytes, and a master FSM
// drains them into a UART by polling its STATUS register and then writing DATA.
module uart_tx_fifo #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int HOLDOFF    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  input  logic                  wb_we,
  input  logic [3:0]            wb_sel,
  input  logic                  wb_stb,
  output logic                  wb_ack,
  output logic [7:0]            m_addr,
  output logic [31:0]           m_dat_o,
  input  logic [31:0]           m_dat_i,
  output logic                  m_we,
  output logic [3:0]            m_sel,
  output logic                  m_stb,
  input  logic                  m_ack,
  output logic                  irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {M_IDLE, M_POLL, M_WRITE, M_HOLD} m_state_t;

  m_state_t        state;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [8:0]      count9;
  logic [HW-1:0]   hold_cnt;
  logic            overflow;
  logic            enable;
  logic            irq_en;
  logic            flush_seen;
  logic            slave_acc;
  logic [5:0]      offset;
  logic            wr_data;
  logic            wr_ctrl;
  logic            flush_now;
  logic            ovf_clr;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic            busy;
  logic            abort_poll;
  logic [31:0]     rd_data;
  logic            unused_bits;

  assign slave_acc  = wb_stb && !wb_ack;
  assign offset     = wb_addr[7:2];
  assign wr_data    = slave_acc && wb_we && (offset == 6'd0);
  assign wr_ctrl    = slave_acc && wb_we && (offset == 6'd2);
  assign flush_now  = wr_ctrl && wb_dat_i[1];
  assign ovf_clr    = wr_ctrl && wb_dat_i[2];
  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign push       = wr_data && !full;
  assign busy       = (state != M_IDLE);
  assign count9     = 9'(count);
  assign pop        = (state == M_WRITE) && m_stb && m_ack && !flush_seen && !flush_now;
  assign abort_poll = flush_seen || flush_now || !enable;
  assign unused_bits = ^{wb_sel, wb_addr, wb_dat_i, m_dat_i};

  // Register read multiplexer; DATA and unmapped offsets read as zero
  always_comb begin
    rd_data = '0;
    case (offset)
      6'd1:    rd_data = {15'd0, count9, 4'd0, busy, overflow, full, empty};
      6'd2:    rd_data = {28'd0, irq_en, 2'b00, enable};
      default: rd_data = '0;
    endcase
  end

  // Slave handshake, read data capture and the persistent CTRL bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack   <= 1'b0;
      wb_dat_o <= '0;
      enable   <= 1'b1;
      irq_en   <= 1'b0;
    end else begin
      wb_ack <= wb_stb && !wb_ack;
      if (slave_acc) begin
        wb_dat_o <= wb_we ? '0 : rd_data;
      end
      if (wr_ctrl) begin
        enable <= wb_dat_i[0];
        irq_en <= wb_dat_i[3];
      end
    end
  end

  // FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wb_dat_i[7:0];
    end
  end

  // Pointers, occupancy and the sticky overflow flag; a full FIFO drops the byte even on a same-cycle pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush_now) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (ovf_clr) begin
        overflow <= 1'b0;
      end else if (wr_data && full) begin
        overflow <= 1'b1;
      end
    end
  end

  // Master FSM: poll UART status, write the head byte, then hold off before the next poll
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= M_IDLE;
      m_stb      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_sel      <= '0;
      m_dat_o    <= '0;
      hold_cnt   <= '0;
      flush_seen <= 1'b0;
    end else begin
      case (state)
        M_IDLE: begin
          flush_seen <= 1'b0;
          if (enable && !empty && !flush_now) begin
            state  <= M_POLL;
            m_stb  <= 1'b1;
            m_we   <= 1'b0;
            m_addr <= 8'h04;
            m_sel  <= 4'hF;
          end
        end
        M_POLL: begin
          if (flush_now) begin
            flush_seen <= 1'b1;
          end
          if (m_stb) begin
            if (m_ack) begin
              if (abort_poll) begin
                state  <= M_IDLE;
                m_stb  <= 1'b0;
                m_sel  <= '0;
                m_addr <= '0;
              end else if (m_dat_i[1]) begin
                state   <= M_WRITE;
                m_we    <= 1'b1;
                m_addr  <= 8'h00;
                m_sel   <= 4'hF;
                m_dat_o <= {24'd0, mem[rd_ptr]};
              end else begin
                m_stb <= 1'b0;
              end
            end
          end else if (abort_poll) begin
            state  <= M_IDLE;
            m_sel  <= '0;
            m_addr <= '0;
          end else begin
            m_stb <= 1'b1;
          end
        end
        M_WRITE: begin
          if (flush_now) begin
            flush_seen <= 1'b1;
          end
          if (m_ack) begin
            state    <= M_HOLD;
            m_stb    <= 1'b0;
            m_we     <= 1'b0;
            m_sel    <= '0;
            m_addr   <= '0;
            hold_cnt <= '0;
          end
        end
        M_HOLD: begin
          if (hold_cnt == HW'(HOLDOFF - 1)) begin
            state <= M_IDLE;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: state <= M_IDLE;
      endcase
    end
  end

  // Interrupt when enabled and the queue has fully drained with the master idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_en && empty && !busy;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a UART responder logs every master
// transaction and a byte-queue reference model predicts what must come out.
module tb_uart_tx_fifo;

  localparam int DEPTH      = 16;
  localparam int ADDR_WIDTH = 8;
  localparam int HOLDOFF    = 4;
  localparam logic [7:0] A_DATA   = 8'h00;
  localparam logic [7:0] A_STATUS = 8'h04;
  localparam logic [7:0] A_CTRL   = 8'h08;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [ADDR_WIDTH-1:0] wb_addr = '0;
  logic [31:0]           wb_dat_i = '0;
  logic [31:0]           wb_dat_o;
  logic                  wb_we = 1'b0;
  logic [3:0]            wb_sel = 4'hF;
  logic                  wb_stb = 1'b0;
  logic                  wb_ack;
  logic [7:0]            m_addr;
  logic [31:0]           m_dat_o;
  logic [31:0]           m_dat_i;
  logic                  m_we;
  logic [3:0]            m_sel;
  logic                  m_stb;
  logic                  m_ack;
  logic                  irq;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int cyc    = 0;

  int poll_total  = 0;
  int busy_until  = 0;
  bit stall_writes = 1'b0;
  int  log_kind[$];
  int  log_cyc[$];
  logic [7:0] log_data[$];
  bit  log_ok[$];

  logic [7:0] model_q[$];
  bit         model_ovf = 1'b0;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .HOLDOFF(HOLDOFF)) dut (
    .clk(clk), .rst(rst),
    .wb_addr(wb_addr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_we(wb_we),
    .wb_sel(wb_sel), .wb_stb(wb_stb), .wb_ack(wb_ack),
    .m_addr(m_addr), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_we(m_we),
    .m_sel(m_sel), .m_stb(m_stb), .m_ack(m_ack), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART responder: acks one cycle after strobe, reports TX_EMPTY=0 for the first busy polls
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ack   <= 1'b0;
      m_dat_i <= '0;
    end else if (m_stb && !m_ack && !(m_we && stall_writes)) begin
      m_ack <= 1'b1;
      log_cyc.push_back(cyc);
      if (m_we) begin
        log_kind.push_back(1);
        log_data.push_back(m_dat_o[7:0]);
        log_ok.push_back(m_addr == 8'h00 && m_sel == 4'hF && m_dat_o[31:8] == 24'd0);
        m_dat_i <= '0;
      end else begin
        log_kind.push_back(0);
        log_data.push_back(8'h00);
        log_ok.push_back(m_addr == 8'h04);
        m_dat_i <= (poll_total < busy_until) ? 32'h0 : 32'h2;
        poll_total = poll_total + 1;
      end
    end else begin
      m_ack <= 1'b0;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, passed=%0d total=%0d", passed, total);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total = total + 1;
    assert (observed === expected) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] addr, input logic [31:0] data);
    bit got = 1'b0;
    wb_addr = addr; wb_dat_i = data; wb_we = 1'b1; wb_stb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (wb_ack) begin got = 1'b1; break; end
    end
    wb_stb = 1'b0; wb_we = 1'b0;
    checkOutput("wb_write_ack", 32'(got), 32'd1);
  endtask

  task automatic readReg(input logic [7:0] addr, output logic [31:0] data);
    bit got = 1'b0;
    wb_addr = addr; wb_we = 1'b0; wb_stb = 1'b1;
    data = 'x;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (wb_ack) begin got = 1'b1; data = wb_dat_o; break; end
    end
    wb_stb = 1'b0;
    checkOutput("wb_read_ack", 32'(got), 32'd1);
  endtask

  task automatic pushByte(input logic [7:0] b);
    applyStimulus(A_DATA, {24'd0, b});
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else model_ovf = 1'b1;
  endtask

  function automatic logic [31:0] expStatus(input bit busy);
    logic [31:0] r;
    int n = model_q.size();
    r = 32'(n) * 32'd256;
    if (busy) r = r | 32'h8;
    if (model_ovf) r = r | 32'h4;
    if (n == DEPTH) r = r | 32'h2;
    if (n == 0) r = r | 32'h1;
    return r;
  endfunction

  function automatic int countKind(input int base, input int kind);
    int c = 0;
    for (int i = base; i < log_kind.size(); i++) if (log_kind[i] == kind) c++;
    return c;
  endfunction

  task automatic waitWrites(input string tag, input int base, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (countKind(base, 1) >= n) break;
      tick(1);
    end
    checkOutput(tag, 32'(countKind(base, 1)), 32'(n));
    tick(HOLDOFF + 6);
  endtask

  task automatic verifyWrites(input string tag, input int base);
    int bad_struct = 0;
    int bad_gap = 0;
    logic [7:0] exp_b;
    for (int i = base; i < log_kind.size(); i++) begin
      if (!log_ok[i]) bad_struct++;
      if (log_kind[i] == 1) begin
        if (model_q.size() > 0) exp_b = model_q.pop_front();
        else exp_b = 8'hxx;
        checkOutput({tag, "_byte"}, {24'd0, log_data[i]}, {24'd0, exp_b});
        if (i == base || log_kind[i-1] != 0) bad_struct++;
        if (i + 1 < log_kind.size() && (log_cyc[i+1] - log_cyc[i] - 2) < HOLDOFF + 1) bad_gap++;
      end
    end
    checkOutput({tag, "_structure"}, 32'(bad_struct), 32'd0);
    checkOutput({tag, "_holdoff_gap"}, 32'(bad_gap), 32'd0);
    checkOutput({tag, "_remaining"}, 32'(model_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  b0;
    int base;
    int bad;
    int prev;
    int npoll;
    int rise;
    int writes_at_rise;
    int lastw;
    bit seen;

    $display("[TB] uart_tx_fifo bench start");

    // Reset state
    tick(3);
    checkOutput("reset_ctrl_outs", {26'd0, m_stb, m_we, wb_ack, irq, 2'b00} | {24'd0, m_addr} | {28'd0, m_sel}, 32'd0);
    checkOutput("reset_m_dat_o", m_dat_o, 32'd0);
    checkOutput("reset_wb_dat_o", wb_dat_o, 32'd0);
    rst = 1'b0;
    tick(2);
    readReg(A_STATUS, rd); checkOutput("status_after_reset", rd, 32'h1);
    readReg(A_CTRL, rd);   checkOutput("ctrl_after_reset", rd, 32'h1);
    readReg(A_DATA, rd);   checkOutput("data_reads_zero", rd, 32'h0);
    applyStimulus(8'h0C, 32'hFFFF_FFFF);
    readReg(8'h0C, rd);    checkOutput("unmapped_reads_zero", rd, 32'h0);
    readReg(A_STATUS, rd); checkOutput("unmapped_write_ignored", rd, 32'h1);

    // Three fixed bytes through an always-ready UART
    base = log_kind.size();
    pushByte(8'h41); pushByte(8'h42); pushByte(8'h43);
    waitWrites("basic_write_count", base, 3, 300);
    checkOutput("basic_poll_count", 32'(countKind(base, 0)), 32'd3);
    verifyWrites("basic", base);
    readReg(A_STATUS, rd); checkOutput("basic_status_empty", rd, 32'h1);

    // UART reports busy for five polls, then ready
    base = log_kind.size();
    busy_until = poll_total + 5;
    pushByte(8'($urandom));
    tick(10);
    readReg(A_STATUS, rd); checkOutput("retry_count_held", rd & 32'h1FF0F, 32'h00108);
    waitWrites("retry_write_count", base, 1, 200);
    bad = 0; prev = -1; npoll = 0;
    for (int i = base; i < log_kind.size(); i++) begin
      if (log_kind[i] == 0) begin
        npoll++;
        if (prev >= 0 && log_cyc[i] - prev != 3) bad++;
        prev = log_cyc[i];
      end else if (log_cyc[i] - prev != 2) bad++;
    end
    checkOutput("retry_poll_count", 32'(npoll), 32'd6);
    checkOutput("retry_spacing", 32'(bad), 32'd0);
    verifyWrites("retry", base);

    // Overflow with the drain disabled, then drain with random busy polls
    applyStimulus(A_CTRL, 32'h0);
    tick(2);
    base = log_kind.size();
    for (int i = 0; i < DEPTH + 1; i++) pushByte(8'($urandom));
    readReg(A_STATUS, rd); checkOutput("overflow_status", rd, expStatus(1'b0));
    checkOutput("overflow_no_traffic", 32'(log_kind.size() - base), 32'd0);
    applyStimulus(A_CTRL, 32'h4);
    model_ovf = 1'b0;
    readReg(A_STATUS, rd); checkOutput("overflow_cleared", rd, expStatus(1'b0));
    readReg(A_CTRL, rd);   checkOutput("ctrl_selfclear_bits", rd, 32'h0);
    busy_until = poll_total + int'($urandom_range(0, 3));
    applyStimulus(A_CTRL, 32'h1);
    waitWrites("drain_write_count", base, DEPTH, DEPTH * 40 + 100);
    verifyWrites("drain", base);
    readReg(A_STATUS, rd); checkOutput("drain_status_empty", rd, 32'h1);

    // Flush while the master is stuck in a write
    applyStimulus(A_CTRL, 32'h0);
    for (int i = 0; i < 5; i++) pushByte(8'($urandom));
    b0 = model_q[0];
    base = log_kind.size();
    stall_writes = 1'b1;
    applyStimulus(A_CTRL, 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (m_stb && m_we) begin seen = 1'b1; break; end
      tick(1);
    end
    checkOutput("flush_reached_write", 32'(seen), 32'd1);
    checkOutput("flush_latched_byte", m_dat_o, {24'd0, b0});
    applyStimulus(A_CTRL, 32'h3);
    model_q.delete();
    readReg(A_STATUS, rd); checkOutput("flush_status_busy", rd, expStatus(1'b1));
    stall_writes = 1'b0;
    tick(40);
    checkOutput("flush_single_write", 32'(countKind(base, 1)), 32'd1);
    checkOutput("flush_written_byte", {24'd0, log_data[log_kind.size() - 1]}, {24'd0, b0});
    readReg(A_STATUS, rd); checkOutput("flush_status_final", rd, 32'h1);

    // Interrupt only after the final write and its holdoff
    applyStimulus(A_CTRL, 32'h8);
    tick(3);
    checkOutput("irq_idle_empty", 32'(irq), 32'd1);
    pushByte(8'($urandom)); pushByte(8'($urandom));
    tick(2);
    checkOutput("irq_low_queued", 32'(irq), 32'd0);
    base = log_kind.size();
    applyStimulus(A_CTRL, 32'h9);
    rise = -1; writes_at_rise = -1;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (irq) begin rise = cyc; writes_at_rise = countKind(base, 1); break; end
    end
    lastw = 0;
    for (int i = base; i < log_kind.size(); i++) if (log_kind[i] == 1) lastw = log_cyc[i];
    checkOutput("irq_writes_before_rise", 32'(writes_at_rise), 32'd2);
    checkOutput("irq_after_holdoff", 32'((rise - lastw) >= HOLDOFF + 2), 32'd1);
    verifyWrites("irq", base);
    base = log_kind.size();
    pushByte(8'($urandom));
    tick(1);
    checkOutput("irq_drop_on_push", 32'(irq), 32'd0);
    waitWrites("irq_push_write", base, 1, 200);
    verifyWrites("irq_push", base);
    checkOutput("irq_high_again", 32'(irq), 32'd1);

    // Asynchronous reset in the middle of a poll
    busy_until = poll_total + 1000;
    base = log_kind.size();
    applyStimulus(A_DATA, {24'd0, 8'($urandom)});
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (m_stb) begin seen = 1'b1; break; end
      tick(1);
    end
    checkOutput("rst_reached_poll", 32'(seen), 32'd1);
    tick(1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_drops_stb", {28'd0, m_stb, m_we, wb_ack, irq}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    busy_until = poll_total;
    readReg(A_STATUS, rd); checkOutput("rst_status", rd, 32'h1);
    readReg(A_CTRL, rd);   checkOutput("rst_ctrl", rd, 32'h1);
    tick(20);
    checkOutput("rst_fifo_lost", 32'(countKind(base, 1)), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter: DEPTH, 16, FIFO entries; power of two, 2..256.
REQ-002 Parameter: ADDR_WIDTH, 8, slave address width.
REQ-003 Parameter: HOLDOFF, 4, idle cycles after each UART DATA write before the next STATUS poll; minimum 2.
REQ-004 Ports: clk input 1, sole clock; reset is asynchronous and active-high.
REQ-005 Ports: rst input 1, asynchronous active-high reset.
REQ-006 Slave ports: wb_addr in ADDR_WIDTH; wb_dat_i in 32; wb_dat_o out 32; wb_we in 1; wb_sel in 4 (ignored); wb_stb in 1; wb_ack out 1.
REQ-007 Master ports, to UART: m_addr out 8; m_dat_o out 32; m_dat_i in 32; m_we out 1; m_sel out 4; m_stb out 1; m_ack in 1.
REQ-008 Interrupt port: irq out 1.

Function
REQ-009 Slave handshake: wb_ack SHALL be registered as wb_stb && !wb_ack, giving one-cycle latency and no back-to-back acks; accesses SHALL take effect in the cycle wb_stb=1 and wb_ack=0.
REQ-010 Slave map, offset wb_addr[7:2]: 0 DATA, write-only push of wb_dat_i[7:0]. 1 STATUS, read. 2 CTRL, read/write. Other offsets read 0 and ignore writes.
REQ-011 STATUS SHALL read {count[8:0] at [16:8], busy[3], overflow[2], full[1], empty[0]}; busy=1 when the master FSM is not in M_IDLE.
REQ-012 CTRL bit fields: [0] enable (reset 1); [1] flush, write-1 self-clearing, reads 0; [2] overflow clear, write-1, reads 0; [3] irq_en (reset 0).
REQ-013 A DATA write while full SHALL drop the byte and set the sticky overflow bit; the drop SHALL apply even if a pop occurs in the same cycle.
REQ-014 Simultaneous push and pop while neither full nor empty SHALL leave count unchanged.
REQ-015 Pointers SHALL wrap modulo DEPTH; count SHALL be $clog2(DEPTH)+1 bits and range 0..DEPTH.
REQ-016 Master FSM states: M_IDLE, M_POLL, M_WRITE, M_HOLD.
REQ-017 M_IDLE -> M_POLL when enable=1 and the FIFO is not empty.
REQ-018 M_POLL drives m_stb=1, m_we=0, m_addr=0x04 and holds them until m_ack.
REQ-019 M_POLL on m_ack with m_dat_i[1]=1 (UART TX_EMPTY) -> M_WRITE; the head byte SHALL be latched into m_dat_o[7:0] with upper bits 0.
REQ-020 M_POLL on m_ack with m_dat_i[1]=0 SHALL deassert m_stb for one cycle, then re-poll.
REQ-021 M_WRITE drives m_stb=1, m_we=1, m_addr=0x00 and m_sel=4'hF until m_ack; on m_ack it SHALL pop one entry and go to M_HOLD.
REQ-022 M_HOLD SHALL count HOLDOFF cycles with m_stb=0, then go to M_IDLE.
REQ-023 m_stb SHALL be 0 in M_IDLE and M_HOLD; master outputs SHALL be registered.
REQ-024 Flush SHALL zero the pointers, count and overflow in the cycle after the write. In M_POLL the FSM SHALL finish the transaction and then go to M_IDLE. In M_WRITE the latched byte completes but no pop occurs.
REQ-025 Clearing enable SHALL not abort an outstanding master transaction; the FSM SHALL return to M_IDLE after it.
REQ-026 irq SHALL be registered as irq_en && empty && !busy.

Reset
REQ-027 While rst=1: pointers, count, overflow 0; enable 1; irq_en 0; FSM M_IDLE; wb_ack, wb_dat_o, m_stb, m_we, m_dat_o, m_addr, m_sel, irq all 0.
REQ-028 Reset asserted mid-transaction SHALL drop m_stb immediately; the FIFO contents are lost.

Verification
REQ-029 Push 0x41,0x42,0x43 with a UART model returning TX_EMPTY=1 -> three DATA writes in order, each preceded by a STATUS read and separated by at least HOLDOFF+1 idle cycles, then STATUS.empty=1.
REQ-030 Model returns TX_EMPTY=0 for 5 polls, then 1 -> 6 STATUS reads, each separated by 1 idle cycle, then 1 DATA write; count decrements only on the write ack.
REQ-031 enable=0, push 17 bytes -> count=16, full=1, overflow=1, byte 17 absent; CTRL overflow clear -> overflow=0.
REQ-032 Flush while in M_WRITE with 5 entries -> write of the latched byte completes, count=0 afterwards, no further writes.
REQ-033 irq_en=1 with 2 bytes queued -> irq=0 until the second write and holdoff finish, then irq=1; one push -> irq=0.
REQ-034 rst pulse during M_POLL -> m_stb=0 in the same cycle, all STATUS fields reset, enable=1.
